// File: rtl/wand_path_sequencer.sv
// Wand sprite path sequencer: walks a packed 4x4 box trace one segment at a time,
// steps the sprite position on a fixed tick and flags non-adjacent segments.
module wand_path_sequencer #(
    parameter int TICK_DIV    = 2000000,
    parameter int STEP_PX     = 2,
    parameter int BOX_PX      = 100,
    parameter int ROW0        = 90,
    parameter int COL0        = 170,
    parameter int DWELL_TICKS = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        learn_mode,
    input  logic        start,
    input  logic [63:0] trace_order,
    input  logic [5:0]  trace_boxes,
    output logic [3:0]  origin,
    output logic [3:0]  next,
    output logic [8:0]  wand_row,
    output logic [9:0]  wand_col,
    output logic        wand_on,
    output logic [3:0]  seg_idx,
    output logic        busy,
    output logic        done,
    output logic        path_err
);

    localparam int STEPS = BOX_PX / STEP_PX;
    localparam int TW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW    = $clog2(DWELL_TICKS + 1);
    localparam int SW    = $clog2(STEPS + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLACE,
        S_DWELL,
        S_MOVE,
        S_FINISH
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [DW-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [SW-1:0] step_cnt_q, step_cnt_d;
    logic [63:0]   trace_q, trace_d;
    logic [3:0]    n_q, n_d;
    logic [3:0]    origin_q, origin_d;
    logic [3:0]    next_q, next_d;
    logic [8:0]    row_q, row_d;
    logic [9:0]    col_q, col_d;
    logic [3:0]    seg_q, seg_d;
    logic          err_q, err_d;

    logic          tick;
    logic [3:0]    n_accept;
    logic [3:0]    seg_delta;

    function automatic logic [3:0] box_at(input logic [63:0] tr, input logic [3:0] k);
        return tr[{k, 2'b00} +: 4];
    endfunction

    function automatic logic [8:0] box_row(input logic [3:0] b);
        return 9'(ROW0 + BOX_PX * int'(b[3:2]));
    endfunction

    function automatic logic [9:0] box_col(input logic [3:0] b);
        return 10'(COL0 + BOX_PX * int'(b[1:0]));
    endfunction

    // Legal moves are one box up/down/left/right without wrapping across a row or the grid.
    function automatic logic seg_legal(input logic [3:0] o, input logic [3:0] n);
        logic [3:0] d;
        logic       ok;
        d  = n - o;
        ok = 1'b0;
        case (d)
            4'h1:    ok = (o[1:0] != 2'd3);
            4'hF:    ok = (o[1:0] != 2'd0);
            4'h4:    ok = (o < 4'd12);
            4'hC:    ok = (o > 4'd3);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    assign tick      = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign n_accept  = (trace_boxes > 6'd15) ? 4'd15 : trace_boxes[3:0];
    assign seg_delta = next_q - origin_q;

    always_comb begin
        // NOTE: every *_d gets its hold value first, so no path through the case infers a latch.
        state_d     = state_q;
        tick_cnt_d  = tick ? '0 : tick_cnt_q + TW'(1);
        dwell_cnt_d = dwell_cnt_q;
        step_cnt_d  = step_cnt_q;
        trace_d     = trace_q;
        n_d         = n_q;
        origin_d    = origin_q;
        next_d      = next_q;
        row_d       = row_q;
        col_d       = col_q;
        seg_d       = seg_q;
        err_d       = err_q;

        if (state_q != S_IDLE && !learn_mode) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && learn_mode) begin
                        trace_d    = trace_order;
                        n_d        = n_accept;
                        seg_d      = '0;
                        err_d      = 1'b0;
                        tick_cnt_d = '0;
                        origin_d   = trace_order[3:0];
                        next_d     = (n_accept == 4'd0) ? trace_order[3:0] : trace_order[7:4];
                        row_d      = box_row(trace_order[3:0]);
                        col_d      = box_col(trace_order[3:0]);
                        state_d    = S_PLACE;
                    end
                end
                S_PLACE: begin
                    dwell_cnt_d = '0;
                    state_d     = S_DWELL;
                end
                S_DWELL: begin
                    if (tick) begin
                        if (dwell_cnt_q == DW'(DWELL_TICKS - 1)) begin
                            dwell_cnt_d = '0;
                            if (seg_q == n_q) begin
                                state_d = S_FINISH;
                            end else if (seg_legal(origin_q, next_q)) begin
                                step_cnt_d = '0;
                                state_d    = S_MOVE;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_FINISH;
                            end
                        end else begin
                            dwell_cnt_d = dwell_cnt_q + DW'(1);
                        end
                    end
                end
                S_MOVE: begin
                    if (tick) begin
                        case (seg_delta)
                            4'h1:    col_d = col_q + 10'(STEP_PX);
                            4'hF:    col_d = col_q - 10'(STEP_PX);
                            4'h4:    row_d = row_q + 9'(STEP_PX);
                            4'hC:    row_d = row_q - 9'(STEP_PX);
                            default: ;
                        endcase
                        if (step_cnt_q == SW'(STEPS - 1)) begin
                            seg_d       = seg_q + 4'd1;
                            origin_d    = next_q;
                            // The final segment leaves next parked on the last box.
                            next_d      = (seg_q + 4'd1 == n_q) ? next_q
                                                                : box_at(trace_q, seg_q + 4'd2);
                            dwell_cnt_d = '0;
                            state_d     = S_DWELL;
                        end else begin
                            step_cnt_d = step_cnt_q + SW'(1);
                        end
                    end
                end
                S_FINISH: state_d = S_IDLE;
                default:  state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: all state is updated with <= so every flop samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the latched trace is reset as well, so no X can ever reach origin/next.
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            dwell_cnt_q <= '0;
            step_cnt_q  <= '0;
            trace_q     <= '0;
            n_q         <= '0;
            origin_q    <= '0;
            next_q      <= '0;
            row_q       <= 9'(ROW0);
            col_q       <= 10'(COL0);
            seg_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            step_cnt_q  <= step_cnt_d;
            trace_q     <= trace_d;
            n_q         <= n_d;
            origin_q    <= origin_d;
            next_q      <= next_d;
            row_q       <= row_d;
            col_q       <= col_d;
            seg_q       <= seg_d;
            err_q       <= err_d;
        end
    end

    assign busy     = (state_q == S_PLACE) || (state_q == S_DWELL) || (state_q == S_MOVE);
    assign wand_on  = busy;
    assign done     = (state_q == S_FINISH) && !err_q;
    assign origin   = origin_q;
    assign next     = next_q;
    assign wand_row = row_q;
    assign wand_col = col_q;
    assign seg_idx  = seg_q;
    assign path_err = err_q;

endmodule
